// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and busy scoreboard for the 16 x 32 register file (ALU vs LDR, round-robin).
// Define RF_WB_BYPASS_EN to let the hazard check see this cycle's grant-clear.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [31:0]       issue_code,
  input  logic              issue_wb,
  output logic              issue_ready,
  input  logic              alu_valid,
  input  logic [AW-1:0]     alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ldr_valid,
  input  logic [AW-1:0]     ldr_dest,
  input  logic [DATA_W-1:0] ldr_data,
  output logic              ldr_ready,
  output logic              rf_wr_en,
  output logic [AW-1:0]     rf_wr_dest,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [NREG-1:0]   busy_mask
);

  logic              ptr_ldr_p0;
  logic              alu_gnt_p0;
  logic              ldr_gnt_p0;
  logic              gnt_p0;
  logic [AW-1:0]     gnt_dest_p0;
  logic [DATA_W-1:0] gnt_data_p0;
  logic [AW-1:0]     dest_p0;
  logic [AW-1:0]     src1_p0;
  logic [AW-1:0]     src2_p0;
  logic [NREG-1:0]   clr_p0;
  logic [NREG-1:0]   set_p0;
  logic [NREG-1:0]   busy_chk_p0;
  logic [NREG-1:0]   busy_p1;
  logic              wr_vld_p1;
  logic [AW-1:0]     wr_dest_p1;
  logic [DATA_W-1:0] wr_data_p1;
  logic              unused_code;

  // Stage p0: decode fields, arbitrate, hazard check
  assign dest_p0     = issue_code[19 +: AW];
  assign src2_p0     = issue_code[15 +: AW];
  assign src1_p0     = issue_code[11 +: AW];
  assign unused_code = ^{issue_code[31:23], issue_code[10:0]};

  // ptr_ldr_p0 = 1 means LDR wins when both request
  assign ldr_gnt_p0  = ldr_valid & (~alu_valid | ptr_ldr_p0);
  assign alu_gnt_p0  = alu_valid & (~ldr_valid | ~ptr_ldr_p0);
  assign gnt_p0      = alu_gnt_p0 | ldr_gnt_p0;
  assign alu_ready   = alu_gnt_p0;
  assign ldr_ready   = ldr_gnt_p0;
  assign gnt_dest_p0 = alu_gnt_p0 ? alu_dest : ldr_dest;
  assign gnt_data_p0 = alu_gnt_p0 ? alu_data : ldr_data;

  always_comb begin
    clr_p0 = '0;
    if (gnt_p0) clr_p0[gnt_dest_p0] = 1'b1;
  end

`ifdef RF_WB_BYPASS_EN
  assign busy_chk_p0 = busy_p1 & ~clr_p0;
`else
  assign busy_chk_p0 = busy_p1;
`endif

  assign issue_ready = ~busy_chk_p0[src1_p0] & ~busy_chk_p0[src2_p0] &
                       ~(issue_wb & busy_chk_p0[dest_p0]);

  always_comb begin
    set_p0 = '0;
    if (issue_valid && issue_ready && issue_wb) set_p0[dest_p0] = 1'b1;
  end

  // Stage p1: registered write port and scoreboard (set applied after clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_ldr_p0 <= 1'b1;
      busy_p1    <= '0;
      wr_vld_p1  <= 1'b0;
      wr_dest_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_vld_p1 <= gnt_p0;
      busy_p1   <= (busy_p1 & ~clr_p0) | set_p0;
      if (gnt_p0) begin
        ptr_ldr_p0 <= alu_gnt_p0;
        wr_dest_p1 <= gnt_dest_p0;
        wr_data_p1 <= gnt_data_p0;
      end
    end
  end

  assign rf_wr_en   = wr_vld_p1;
  assign rf_wr_dest = wr_dest_p1;
  assign rf_wr_data = wr_data_p1;
  assign busy_mask  = busy_p1;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations plus randomized
// handshaking traffic compared every cycle against a turn/array-based reference model.
module tb_regfile_wb_arbiter;

`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_wb, issue_ready;
  logic [31:0] issue_code;
  logic        alu_valid, alu_ready, ldr_valid, ldr_ready;
  logic [3:0]  alu_dest, ldr_dest, rf_wr_dest;
  logic [31:0] alu_data, ldr_data, rf_wr_data;
  logic        rf_wr_en;
  logic [15:0] busy_mask;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_code(issue_code), .issue_wb(issue_wb),
    .issue_ready(issue_ready),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .ldr_valid(ldr_valid), .ldr_dest(ldr_dest), .ldr_data(ldr_data), .ldr_ready(ldr_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_dest(rf_wr_dest), .rf_wr_data(rf_wr_data),
    .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit mdl_on = 1'b0;

  // reference model state
  bit        m_ldr_turn = 1'b1;
  bit        m_busy [16];
  bit        m_wr_en = 1'b0;
  bit [3:0]  m_wr_dest = 4'd0;
  bit [31:0] m_wr_data = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [3:0] d, input logic [3:0] s2, input logic [3:0] s1);
    mk = {9'd0, d, s2, s1, 11'd0};
  endfunction

  function automatic void exp_grant(output bit ga, output bit gl);
    ga = 1'b0;
    gl = 1'b0;
    if (alu_valid && ldr_valid) begin
      if (m_ldr_turn) gl = 1'b1;
      else            ga = 1'b1;
    end else begin
      ga = alu_valid;
      gl = ldr_valid;
    end
  endfunction

  function automatic bit exp_issue_ready();
    bit b [16];
    bit ga, gl;
    for (int i = 0; i < 16; i++) b[i] = m_busy[i];
    exp_grant(ga, gl);
    if (BYP && ga) b[alu_dest] = 1'b0;
    if (BYP && gl) b[ldr_dest] = 1'b0;
    exp_issue_ready = !b[issue_code[14:11]] && !b[issue_code[18:15]] &&
                      !(issue_wb && b[issue_code[22:19]]);
  endfunction

  function automatic logic [15:0] m_busy_vec();
    for (int i = 0; i < 16; i++) m_busy_vec[i] = m_busy[i];
  endfunction

  // model update on clock edge / async reset
  initial forever begin
    bit ga, gl, ir;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ldr_turn = 1'b1;
      for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
      m_wr_en = 1'b0; m_wr_dest = '0; m_wr_data = '0;
    end else begin
      exp_grant(ga, gl);
      ir = exp_issue_ready();
      if (ga) begin
        m_wr_en = 1'b1; m_wr_dest = alu_dest; m_wr_data = alu_data;
        m_busy[alu_dest] = 1'b0; m_ldr_turn = 1'b1;
      end else if (gl) begin
        m_wr_en = 1'b1; m_wr_dest = ldr_dest; m_wr_data = ldr_data;
        m_busy[ldr_dest] = 1'b0; m_ldr_turn = 1'b0;
      end else begin
        m_wr_en = 1'b0;
      end
      if (issue_valid && ir && issue_wb) m_busy[issue_code[22:19]] = 1'b1;
    end
  end

  // per-cycle comparison against the model
  initial forever begin
    bit ga, gl;
    @(negedge clk);
    if (mdl_on) begin
      exp_grant(ga, gl);
      chk("alu_ready",   {31'd0, alu_ready},   {31'd0, ga});
      chk("ldr_ready",   {31'd0, ldr_ready},   {31'd0, gl});
      chk("issue_ready", {31'd0, issue_ready}, {31'd0, exp_issue_ready()});
      chk("rf_wr_en",    {31'd0, rf_wr_en},    {31'd0, m_wr_en});
      chk("rf_wr_dest",  {28'd0, rf_wr_dest},  {28'd0, m_wr_dest});
      chk("rf_wr_data",  rf_wr_data,           m_wr_data);
      chk("busy_mask",   {16'd0, busy_mask},   {16'd0, m_busy_vec()});
    end
  end

  function automatic logic [3:0] pick_dest();
    logic [3:0] d;
    d = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 3) != 0)
      for (int k = 0; k < 16; k++) begin
        if (m_busy[d]) break;
        d = 4'($urandom_range(0, 15));
      end
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] g_exp [4];
    logic [4:0] g_act;
    int a_i, l_i;
    bit a_done, l_done, i_done;
    logic [31:0] c;

    rst_n = 1'b1;
    issue_valid = 0; issue_code = 0; issue_wb = 0;
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    ldr_valid = 0; ldr_dest = 0; ldr_data = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mdl_on = 1'b1;

    @(negedge clk);
    chk("reset wr_en", {31'd0, rf_wr_en}, 32'd0);
    chk("reset busy",  {16'd0, busy_mask}, 32'd0);
    chk("reset dest",  {28'd0, rf_wr_dest}, 32'd0);

    // single ALU request
    step(); alu_valid = 1; alu_dest = 4'd5; alu_data = 32'hDEADBEEF;
    @(negedge clk); chk("single alu_ready", {31'd0, alu_ready}, 32'd1);
    step(); alu_valid = 0;
    @(negedge clk);
    chk("single wr_en", {31'd0, rf_wr_en}, 32'd1);
    chk("single dest",  {28'd0, rf_wr_dest}, 32'd5);
    chk("single data",  rf_wr_data, 32'hDEADBEEF);
    step();
    @(negedge clk); chk("single wr_en t+2", {31'd0, rf_wr_en}, 32'd0);

    // contention: grant order LDR(3), ALU(1), LDR(4), ALU(2)
    g_exp[0] = {1'b1, 4'd3}; g_exp[1] = {1'b0, 4'd1};
    g_exp[2] = {1'b1, 4'd4}; g_exp[3] = {1'b0, 4'd2};
    a_i = 0; l_i = 0;
    step();
    alu_valid = 1; alu_dest = 4'd1; alu_data = 32'hA1;
    ldr_valid = 1; ldr_dest = 4'd3; ldr_data = 32'hB3;
    for (int cy = 0; cy < 6; cy++) begin
      @(negedge clk);
      if (cy < 4) begin
        g_act = ldr_ready ? {1'b1, ldr_dest} : {1'b0, alu_dest};
        chk("contention grant", {27'd0, g_act}, {27'd0, g_exp[cy]});
        chk("contention one grant", {31'd0, alu_ready & ldr_ready}, 32'd0);
      end
      if (cy >= 1 && cy <= 4) begin
        chk("contention wr_en", {31'd0, rf_wr_en}, 32'd1);
        chk("contention wr_dest", {28'd0, rf_wr_dest}, {28'd0, g_exp[cy-1][3:0]});
      end
      if (cy == 5) chk("contention wr_en end", {31'd0, rf_wr_en}, 32'd0);
      a_done = alu_valid && alu_ready;
      l_done = ldr_valid && ldr_ready;
      step();
      if (a_done) begin
        a_i++;
        if (a_i == 2) alu_valid = 0; else begin alu_dest = 4'd2; alu_data = 32'hA2; end
      end
      if (l_done) begin
        l_i++;
        if (l_i == 2) ldr_valid = 0; else begin ldr_dest = 4'd4; ldr_data = 32'hB4; end
      end
    end

    // RAW stall on r7
    issue_valid = 1; issue_code = mk(4'd7, 4'd0, 4'd0); issue_wb = 1;
    @(negedge clk); chk("raw first ready", {31'd0, issue_ready}, 32'd1);
    step(); issue_code = mk(4'd0, 4'd0, 4'd7); issue_wb = 0;
    @(negedge clk);
    chk("raw busy", {16'd0, busy_mask}, 32'h0080);
    chk("raw stall", {31'd0, issue_ready}, 32'd0);
    step();
    @(negedge clk); chk("raw stall hold", {31'd0, issue_ready}, 32'd0);
    step(); alu_valid = 1; alu_dest = 4'd7; alu_data = 32'h77;
    @(negedge clk); chk("raw grant-cycle ready", {31'd0, issue_ready}, {31'd0, BYP});
    step(); alu_valid = 0;
    @(negedge clk);
    chk("raw ready after", {31'd0, issue_ready}, 32'd1);
    chk("raw busy cleared", {16'd0, busy_mask}, 32'h0000);
    step(); issue_valid = 0;

    // WAW / set-wins on r9
    if (BYP) begin
      issue_valid = 1; issue_code = mk(4'd9, 4'd1, 4'd1); issue_wb = 1;
      step(); issue_valid = 0;
    end
    issue_valid = 1; issue_code = mk(4'd9, 4'd1, 4'd1); issue_wb = 1;
    alu_valid = 1; alu_dest = 4'd9; alu_data = 32'h99;
    @(negedge clk); chk("waw issue_ready", {31'd0, issue_ready}, 32'd1);
    step(); issue_valid = 0; alu_valid = 0;
    @(negedge clk);
    chk("waw busy set-wins", {16'd0, busy_mask}, 32'h0200);
    chk("waw wr_dest", {28'd0, rf_wr_dest}, 32'd9);

    // non-writing issue to a busy dest
    step(); issue_valid = 1; issue_code = mk(4'd3, 4'd1, 4'd1); issue_wb = 1;
    step(); issue_wb = 0;
    @(negedge clk);
    chk("nowb busy before", {16'd0, busy_mask}, 32'h0208);
    chk("nowb ready", {31'd0, issue_ready}, 32'd1);
    step(); issue_valid = 0;
    @(negedge clk); chk("nowb busy after", {16'd0, busy_mask}, 32'h0208);

    // mid-stream async reset; pointer left ALU-first beforehand
    step(); ldr_valid = 1; ldr_dest = 4'd2; ldr_data = 32'h22;
    step(); ldr_valid = 0; alu_valid = 1; alu_dest = 4'd4; alu_data = 32'h44;
    @(negedge clk); chk("pre-reset wr_en", {31'd0, rf_wr_en}, 32'd1);
    #1 rst_n = 0;
    #1;
    chk("async rst wr_en", {31'd0, rf_wr_en}, 32'd0);
    chk("async rst busy", {16'd0, busy_mask}, 32'd0);
    chk("async rst dest", {28'd0, rf_wr_dest}, 32'd0);
    chk("async rst data", rf_wr_data, 32'd0);
    ldr_valid = 1; ldr_dest = 4'd6; ldr_data = 32'h66;
    step(); rst_n = 1;
    @(negedge clk);
    chk("post-rst ldr first", {31'd0, ldr_ready}, 32'd1);
    chk("post-rst alu wait", {31'd0, alu_ready}, 32'd0);
    step(); ldr_valid = 0;
    @(negedge clk);
    chk("post-rst alu next", {31'd0, alu_ready}, 32'd1);
    chk("post-rst wr_dest", {28'd0, rf_wr_dest}, 32'd6);
    step(); alu_valid = 0;

    // randomized traffic with valid/ready holding
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      a_done = alu_valid && alu_ready;
      l_done = ldr_valid && ldr_ready;
      i_done = issue_valid && issue_ready;
      step();
      if (!alu_valid || a_done) begin
        alu_valid = ($urandom_range(0, 99) < 55);
        alu_dest = pick_dest(); alu_data = $urandom;
      end
      if (!ldr_valid || l_done) begin
        ldr_valid = ($urandom_range(0, 99) < 55);
        ldr_dest = pick_dest(); ldr_data = $urandom;
      end
      if (!issue_valid || i_done || $urandom_range(0, 3) == 0) begin
        c = $urandom;
        c[22:19] = 4'($urandom_range(0, 15));
        c[18:15] = 4'($urandom_range(0, 15));
        c[14:11] = 4'($urandom_range(0, 15));
        issue_valid = ($urandom_range(0, 99) < 70);
        issue_code = c;
        issue_wb = ($urandom_range(0, 99) < 60);
      end
    end

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 16 x 32-bit register file. Arbitrates write-back requests from the ALU path and the LDR (load) path.
- Keeps a per-register busy scoreboard that stalls instruction issue on RAW and WAW hazards.
- Sits between decode/issue, the execute/memory stages and the register-file write inputs (write-select, destination, data).

Parameters:
DATA_W, 32, write-back data width
NREG, 16, number of architectural registers
AW, 4, register index width (log2 NREG)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
issue_valid  input  1  decoder presents an instruction
issue_code  input  32  instruction word: dest [22:19], src2 [18:15], src1 [14:11]
issue_wb  input  1  instruction will write back to dest
issue_ready  output  1  no hazard; instruction accepted when issue_valid && issue_ready
alu_valid  input  1  ALU write-back request
alu_dest  input  AW  ALU destination index
alu_data  input  DATA_W  ALU result
alu_ready  output  1  ALU request granted this cycle
ldr_valid  input  1  load write-back request
ldr_dest  input  AW  load destination index
ldr_data  input  DATA_W  load data
ldr_ready  output  1  load request granted this cycle
rf_wr_en  output  1  register-file write strobe (drives write-select)
rf_wr_dest  output  AW  register-file write index
rf_wr_data  output  DATA_W  register-file write data
busy_mask  output  NREG  scoreboard, bit i = register i has a pending write

Behaviour:
- Reset (rst_n low, asynchronous):
  - rf_wr_en=0, rf_wr_dest=0, rf_wr_data=0, busy_mask=0.
  - Round-robin pointer set to LDR-first.
  - In-flight requests are dropped; the requesters must re-present them after reset.
- Handshake rules:
  - A requester holds valid, dest and data stable until it sees ready.
  - ready is combinational from the valids and the pointer. Ready is never asserted without the matching valid.
- Arbitration, evaluated every cycle:
  - One valid: that request is granted.
  - Both valid: the request pointed to by the round-robin pointer wins.
  - After any grant, the pointer moves to the other requester.
  - No grant: pointer unchanged.
  - At most one grant per cycle.
- Write-back latency:
  - A grant in cycle t registers dest/data. rf_wr_en=1 with those values in cycle t+1 only.
  - No grant in t gives rf_wr_en=0 in t+1. rf_wr_dest/rf_wr_data hold their last values.
  - Back-to-back grants give a continuous stream of rf_wr_en, one write per cycle.
- Scoreboard:
  - On an accepted issue with issue_wb=1, set busy[dest] at the clock edge.
  - On a grant to register d, clear busy[d] at the same edge that registers the write.
  - Issue set and grant clear on the same index in the same cycle: set wins, bit stays 1.
  - A grant to a register that is not busy is still written; busy is unchanged.
- Hazard check (combinational, on the current busy_mask):
  - issue_ready = !busy[src1] && !busy[src2] && !(issue_wb && busy[dest]).
  - issue_ready does not depend on issue_valid.
  - With the optional feature off, a register cleared in cycle t is visible as free in t+1. This costs one bubble cycle.
- r0 gets no special treatment: it is tracked and writable like any other register.

Optional Feature:
- Macro RF_WB_BYPASS_EN.
- Defined:
  - The hazard check uses busy_mask with this cycle's grant-clear already applied.
  - An instruction waiting on register d issues in the same cycle that d is granted. The register file sees the write in the next cycle, before the issued instruction reads.
- Undefined: the hazard check uses the registered busy_mask only, as described above.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with alu_valid=1 -> rf_wr_en=0 and busy_mask=0 immediately. After release, the first dual request grants LDR.
- Single ALU request: alu_valid=1, dest=5, data=0xDEADBEEF in cycle t -> alu_ready=1 in t; rf_wr_en=1, dest=5, data=0xDEADBEEF in t+1; rf_wr_en=0 in t+2.
- Contention, both valid for 4 cycles:
  - ALU requests dest 1,2; LDR requests dest 3,4.
  - Required grant order: LDR(3), ALU(1), LDR(4), ALU(2).
  - rf_wr_en is high for 4 consecutive cycles.
- RAW stall:
  - Issue with dest=7, issue_wb=1 is accepted -> busy_mask=0x0080.
  - A following issue with src1=7 sees issue_ready=0 until ALU dest=7 is granted.
  - issue_ready=1 one cycle after the grant; with RF_WB_BYPASS_EN, in the grant cycle itself.
- WAW and set-wins: busy[9]=1; ALU grant on dest 9 in the same cycle as an accepted issue with dest=9, issue_wb=1 -> busy[9] stays 1 and rf_wr_dest=9 next cycle.
- Non-writing issue: issue_wb=0, dest=3 while busy[3]=1 and sources free -> issue_ready=1 and busy_mask unchanged.
